// File: rtl/regfile_mp_pkg.sv
// rtl/regfile_mp_pkg.sv - shared register index constants and clear FSM state encodings
package regfile_mp_pkg;

  localparam int REG_ZERO = 0;
  localparam int REG_V0   = 2;
  localparam int REG_A0   = 4;
  localparam int REG_RA   = 31;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_clear_fsm.sv
// rtl/regfile_clear_fsm.sv - sequential clear engine: walks every entry once after reset, then raises ready
module regfile_clear_fsm
  import regfile_mp_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          ready,
  output logic          clr_en,
  output logic [AW-1:0] clr_idx
);

  rf_state_e     state;
  logic [AW-1:0] idx;

  assign clr_idx = idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RF_CLEAR;
      idx    <= '0;
      ready  <= 1'b0;
      clr_en <= 1'b1;
    end else begin
      case (state)
        RF_CLEAR: begin
          if (idx == AW'(DEPTH - 1)) begin
            state  <= RF_RUN;
            idx    <= '0;
            ready  <= 1'b1;
            clr_en <= 1'b0;
          end else begin
            idx <= idx + AW'(1);
          end
        end
        RF_RUN: begin
          ready  <= 1'b1;
          clr_en <= 1'b0;
        end
        default: begin
          state  <= RF_CLEAR;
          idx    <= '0;
          ready  <= 1'b0;
          clr_en <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with two write ports, write-to-read bypass and clear engine
// Optional issue scoreboard enabled by defining REGFILE_SCOREBOARD_EN.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int NUM_RD     = 2,
  parameter int ZERO_REG   = 1,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         ready,
  input  logic                         we0,
  input  logic [AW-1:0]                waddr0,
  input  logic [DATA_WIDTH-1:0]        wdata0,
  input  logic                         we1,
  input  logic [AW-1:0]                waddr1,
  input  logic [DATA_WIDTH-1:0]        wdata1,
  input  logic [NUM_RD*AW-1:0]         raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
  input  logic [AW-1:0]                dbg_addr,
  output logic [DATA_WIDTH-1:0]        dbg_data,
  input  logic                         iss_valid,
  input  logic [AW-1:0]                iss_addr,
  output logic [NUM_RD-1:0]            busy
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  clr_en;
  logic [AW-1:0]         clr_idx;
  logic                  we0_act, we1_act;
  logic                  w0_ok, w1_ok;

  regfile_clear_fsm #(.DEPTH(DEPTH), .AW(AW)) u_clear (
    .clk     (clk),
    .rst     (rst),
    .ready   (ready),
    .clr_en  (clr_en),
    .clr_idx (clr_idx)
  );

  assign we0_act = ready & we0;
  assign we1_act = ready & we1;
  assign w0_ok   = we0_act & ~((ZERO_REG != 0) && (waddr0 == AW'(REG_ZERO)));
  assign w1_ok   = we1_act & ~((ZERO_REG != 0) && (waddr1 == AW'(REG_ZERO)));

  // W1 is written last so it wins a same-address collision with W0.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_idx] <= '0;
    end else begin
      if (w0_ok) mem[waddr0] <= wdata0;
      if (w1_ok) mem[waddr1] <= wdata1;
    end
  end

  assign dbg_data = ready ? mem[dbg_addr] : '0;

`ifdef REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_nxt;
  logic             iss_act;

  assign iss_act = ready & iss_valid;

  // Set is applied after the clears: a new issue outranks a retiring producer.
  always_comb begin
    busy_nxt = busy_q;
    if (we0_act) busy_nxt[waddr0] = 1'b0;
    if (we1_act) busy_nxt[waddr1] = 1'b0;
    if (iss_act) busy_nxt[iss_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || clr_en) busy_q <= '0;
    else               busy_q <= busy_nxt;
  end
`else
  logic unused_iss;
  assign unused_iss = ^{iss_valid, iss_addr};
  assign busy       = '0;
`endif

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]         ra;
    logic [DATA_WIDTH-1:0] rv;
    logic                  is_zero;

    assign ra      = raddr[k*AW +: AW];
    assign is_zero = (ZERO_REG != 0) && (ra == AW'(REG_ZERO));

    always_comb begin
      rv = '0;
      if (!ready || is_zero)               rv = '0;
      else if (we1_act && waddr1 == ra)    rv = wdata1;
      else if (we0_act && waddr0 == ra)    rv = wdata0;
      else                                 rv = mem[ra];
    end

    assign rdata[k*DATA_WIDTH +: DATA_WIDTH] = rv;

`ifdef REGFILE_SCOREBOARD_EN
    logic wr_hit, iss_hit;
    assign wr_hit  = (we0_act && waddr0 == ra) || (we1_act && waddr1 == ra);
    assign iss_hit = iss_act && (iss_addr == ra);
    assign busy[k] = ready & busy_q[ra] & ~is_zero & ~(wr_hit & ~iss_hit);
`endif
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - randomized and directed check of regfile_mp against a behavioural model
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int NRD   = 3;
  localparam int AW    = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              ready;
  logic              we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0]     waddr0 = '0, waddr1 = '0;
  logic [DW-1:0]     wdata0 = '0, wdata1 = '0;
  logic [NRD*AW-1:0] raddr = '0;
  logic [NRD*DW-1:0] rdata;
  logic [AW-1:0]     dbg_addr = '0;
  logic [DW-1:0]     dbg_data;
  logic              iss_valid = 1'b0;
  logic [AW-1:0]     iss_addr = '0;
  logic [NRD-1:0]    busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_RD(NRD), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(raddr), .rdata(rdata),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .busy(busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: register contents, pending-producer flags, cycles since reset.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_busy [DEPTH];
  int            m_cnt = 0;
  bit            m_started = 0;

  function automatic bit m_ready();
    return m_started && (m_cnt >= DEPTH);
  endfunction

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    if (!m_ready() || a == 0)       return '0;
    if (we1 && waddr1 == a)         return wdata1;
    if (we0 && waddr0 == a)         return wdata0;
    return m_mem[a];
  endfunction

  function automatic bit exp_busy(input logic [AW-1:0] a);
`ifdef REGFILE_SCOREBOARD_EN
    bit wr, iss;
    if (!m_ready() || a == 0) return 1'b0;
    wr  = (we0 && waddr0 == a) || (we1 && waddr1 == a);
    iss = iss_valid && iss_addr == a;
    if (wr && !iss) return 1'b0;
    return m_busy[a];
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_started = 1;
      m_cnt     = 0;
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i]  = '0;
        m_busy[i] = 1'b0;
      end
    end else if (!m_started) begin
      m_cnt = 0;
    end else if (m_cnt < DEPTH) begin
      m_cnt++;
    end else begin
      if (we0 && waddr0 != 0) m_mem[waddr0] = wdata0;
      if (we1 && waddr1 != 0) m_mem[waddr1] = wdata1;
      if (we0) m_busy[waddr0] = 1'b0;
      if (we1) m_busy[waddr1] = 1'b0;
      if (iss_valid) m_busy[iss_addr] = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      check("ready", {63'd0, ready}, {63'd0, m_ready()});
      for (int k = 0; k < NRD; k++) begin
        check($sformatf("rdata%0d", k), {32'd0, rdata[k*DW +: DW]},
              {32'd0, exp_read(raddr[k*AW +: AW])});
        check($sformatf("busy%0d", k), {63'd0, busy[k]},
              {63'd0, exp_busy(raddr[k*AW +: AW])});
      end
      check("dbg_data", {32'd0, dbg_data},
            {32'd0, m_ready() ? m_mem[dbg_addr] : 32'd0});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; iss_valid = 1'b0;
  endtask

  task automatic set_all_raddr(input logic [AW-1:0] a);
    for (int k = 0; k < NRD; k++) raddr[k*AW +: AW] = a;
  endtask

  task automatic count_to_ready(input string name);
    int cnt;
    cnt = 0;
    while (!ready && cnt < 100) begin
      tick();
      cnt++;
    end
    check(name, 64'(cnt), 64'd32);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, DEPTH - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    // Reset and clear duration; reads stay 0 while clearing.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hDEAD_BEEF;
    set_all_raddr(5'd3);
    @(negedge clk);
    check("clear_read0", {32'd0, rdata[DW-1:0]}, 64'd0);
    check("clear_ready", {63'd0, ready}, 64'd0);
    count_to_ready("ready_latency");
    idle();

    // Reset mid-clear restarts the walk.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_to_ready("restart_latency");

    // Same-cycle collision: W1 wins, debug tap shows it one cycle later.
    dbg_addr = 5'd5;
    set_all_raddr(5'd5);
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h0000_AAAA;
    we1 = 1'b1; waddr1 = 5'd5; wdata1 = 32'h0000_5555;
    @(negedge clk);
    check("collide_bypass", {32'd0, rdata[DW-1:0]}, 64'h5555);
    check("dbg_before", {32'd0, dbg_data}, 64'd0);
    tick();
    idle();
    @(negedge clk);
    check("dbg_after", {32'd0, dbg_data}, 64'h5555);

    // Writes to the zero register vanish.
    set_all_raddr(5'd0);
    dbg_addr = 5'd0;
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFF_FFFF;
    @(negedge clk);
    check("zero_same", {32'd0, rdata[DW-1:0]}, 64'd0);
    tick();
    idle();
    @(negedge clk);
    check("zero_next", {32'd0, rdata[DW-1:0]}, 64'd0);
    check("zero_dbg", {32'd0, dbg_data}, 64'd0);

    // All read ports see a bypassed write.
    set_all_raddr(5'd7);
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h0000_1234;
    @(negedge clk);
    for (int k = 0; k < NRD; k++)
      check($sformatf("multi_port%0d", k), {32'd0, rdata[k*DW +: DW]}, 64'h1234);
    tick();
    idle();

`ifdef REGFILE_SCOREBOARD_EN
    set_all_raddr(5'd9);
    iss_valid = 1'b1; iss_addr = 5'd9;
    @(negedge clk);
    check("sb_iss_same", {63'd0, busy[0]}, 64'd0);
    tick();
    idle();
    @(negedge clk);
    check("sb_iss_next", {63'd0, busy[0]}, 64'd1);
    iss_valid = 1'b1; iss_addr = 5'd9;
    we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h99;
    @(negedge clk);
    check("sb_set_clr_same", {63'd0, busy[0]}, 64'd1);
    tick();
    idle();
    @(negedge clk);
    check("sb_set_wins", {63'd0, busy[0]}, 64'd1);
    we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h77;
    @(negedge clk);
    check("sb_wb_same", {63'd0, busy[0]}, 64'd0);
    tick();
    idle();
    @(negedge clk);
    check("sb_wb_after", {63'd0, busy[0]}, 64'd0);
`endif

    // Randomized traffic, checked every cycle by the compare process.
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 499) == 0);
      we0       = $urandom_range(0, 1) == 1;
      we1       = $urandom_range(0, 2) == 0;
      waddr0    = rand_addr();
      waddr1    = rand_addr();
      wdata0    = $urandom;
      wdata1    = $urandom;
      iss_valid = $urandom_range(0, 2) == 0;
      iss_addr  = rand_addr();
      dbg_addr  = rand_addr();
      for (int k = 0; k < NRD; k++) raddr[k*AW +: AW] = rand_addr();
      tick();
    end
    rst = 1'b0;
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
